// File: rtl/qk_score_sequencer_if.sv
// K-memory read port, dot-product feed/return, and the indexed score stream.
// Score handshake: a transfer happens on a rising clk edge where score_valid and score_ready are both high.
interface qk_score_sequencer_if #(
    parameter int ARRAYSIZE = 1024,
    parameter int ADDR_W    = 6
);
    logic                 k_rd_en;
    logic [ADDR_W-1:0]    k_rd_addr;
    logic [ARRAYSIZE-1:0] k_rd_data;
    logic [ARRAYSIZE-1:0] dp_vector;
    logic [ARRAYSIZE-1:0] dp_matrix;
    logic [15:0]          dp_result;
    logic                 score_valid;
    logic                 score_ready;
    logic [15:0]          score_data;
    logic [ADDR_W-1:0]    score_idx;

    modport master (
        output k_rd_en, k_rd_addr, dp_vector, dp_matrix, score_valid, score_data, score_idx,
        input  k_rd_data, dp_result, score_ready
    );

    modport slave (
        input  k_rd_en, k_rd_addr, dp_vector, dp_matrix, score_valid, score_data, score_idx,
        output k_rd_data, dp_result, score_ready
    );
endinterface

// File: rtl/qk_score_sequencer.sv
// Streams K rows into the Q.K dot-product unit and returns indexed scores.
// Issue is limited by credits, so results from the stall-free pipeline always find room in the FIFO.
module qk_score_sequencer #(
    parameter int ARRAYSIZE  = 1024,
    parameter int MAX_ROWS   = 64,
    parameter int ADDR_W     = 6,
    parameter int DP_LATENCY = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int CNT_W     = $clog2(MAX_ROWS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ARRAYSIZE-1:0]     q_vec,
    input  logic [CNT_W-1:0]         num_rows,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               dbg_state,
    qk_score_sequencer_if.master     bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

    localparam int IW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [IW-1:0] DEPTH_C  = IW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    state_t               state, state_nxt;
    logic                 accept, issue, pop, push, done_nxt;
    logic [CNT_W-1:0]     rows_q, issue_cnt, pop_cnt;
    logic [IW-1:0]        inflight;
    logic [ARRAYSIZE-1:0] dp_vector_q;

    logic [DP_LATENCY:0]  tag_vld;
    logic [ADDR_W-1:0]    tag_idx [DP_LATENCY+1];

    logic [16+ADDR_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [IW-1:0]        count;

    assign pop  = bus.score_valid && bus.score_ready;
    assign push = tag_vld[DP_LATENCY];

    // done is registered off the pop that completes the run, so it lands one cycle after the final transfer.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (num_rows == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                issue = (issue_cnt < rows_q) && (inflight < DEPTH_C);
                if (issue && (issue_cnt + CNT_W'(1) == rows_q))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop_cnt + CNT_W'(pop) == rows_q) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            rows_q      <= '0;
            issue_cnt   <= '0;
            pop_cnt     <= '0;
            inflight    <= '0;
            dp_vector_q <= '0;
            tag_vld     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            state   <= state_nxt;
            done    <= done_nxt;
            tag_vld <= {tag_vld[DP_LATENCY-1:0], issue};
            if (accept) begin
                rows_q      <= num_rows;
                dp_vector_q <= q_vec;
                issue_cnt   <= '0;
                pop_cnt     <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
                if (pop)   pop_cnt   <= pop_cnt + CNT_W'(1);
            end
            case ({issue, pop})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + IW'(1);
                2'b01:   count <= count - IW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        tag_idx[0] <= issue_cnt[ADDR_W-1:0];
        for (int i = 1; i <= DP_LATENCY; i++)
            tag_idx[i] <= tag_idx[i-1];
        if (push)
            mem[wr_ptr] <= {tag_idx[DP_LATENCY], bus.dp_result};
    end

    assign busy          = (state != S_IDLE);
    assign dbg_state     = state;
    assign bus.k_rd_en   = issue;
    assign bus.k_rd_addr = issue ? issue_cnt[ADDR_W-1:0] : '0;
    assign bus.dp_vector = dp_vector_q;
    assign bus.dp_matrix = bus.k_rd_data;
    assign bus.score_valid = (count != '0);
    // Head is forced to zero while empty so idle outputs are deterministic.
    assign {bus.score_idx, bus.score_data} = bus.score_valid ? mem[rd_ptr] : '0;
endmodule
